// File: rtl/div_pkg.sv
// div_pkg
//   Shared definitions for the divider sequencing controller: the controller
//   state enum, the default operand width and the bit positions of the
//   quotient and remainder inside the divider's packed result word.
//   No ports (package).

package div_pkg;

  // Default operand/result width of the shared divider.
  localparam int DIV_DATA_WIDTH = 32;

  // The divider packs {quotient, remainder} into one 2*width word.
  localparam int DIV_QUOT_MSB = 2 * DIV_DATA_WIDTH - 1;
  localparam int DIV_QUOT_LSB = DIV_DATA_WIDTH;
  localparam int DIV_REM_MSB  = DIV_DATA_WIDTH - 1;
  localparam int DIV_REM_LSB  = 0;

  // Controller states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_result_sel.sv
// div_result_sel
//   Combinational quotient/remainder select. Slices a packed
//   {quotient, remainder} word and returns one half. Used both for real
//   divider results and for the locally built zero-divisor result.
// Ports:
//   div_result_i  in  2*DATA_WIDTH  packed {quotient, remainder}
//   rem_sel_i     in  1             1 = remainder, 0 = quotient
//   result_o      out DATA_WIDTH    selected half

module div_result_sel
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
  input  logic [2*DATA_WIDTH-1:0] div_result_i,
  input  logic                    rem_sel_i,
  output logic [DATA_WIDTH-1:0]   result_o
);

  // The package slice constants describe the default width; any other
  // width derives the same layout from DATA_WIDTH.
  localparam int QUOT_MSB = (DATA_WIDTH == DIV_DATA_WIDTH) ? DIV_QUOT_MSB : 2 * DATA_WIDTH - 1;
  localparam int QUOT_LSB = (DATA_WIDTH == DIV_DATA_WIDTH) ? DIV_QUOT_LSB : DATA_WIDTH;
  localparam int REM_MSB  = (DATA_WIDTH == DIV_DATA_WIDTH) ? DIV_REM_MSB  : DATA_WIDTH - 1;
  localparam int REM_LSB  = (DATA_WIDTH == DIV_DATA_WIDTH) ? DIV_REM_LSB  : 0;

  // Pick the requested half of the packed result.
  always_comb begin
    if (rem_sel_i) result_o = div_result_i[REM_MSB:REM_LSB];
    else           result_o = div_result_i[QUOT_MSB:QUOT_LSB];
  end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl
//   Sequencing controller between the execute stage and the shared divider.
//   Latches operands, issues a one-cycle request, stalls the pipeline while
//   the divider runs, holds the selected quotient/remainder until the
//   execute stage acknowledges it, and drains results of operations that
//   were cancelled by a flush. A WAIT/DRAIN cycle budget of TIMEOUT guards
//   against a divider that never answers (sticky timeout_o).
//   Optional macro DIV_ZERO_BYPASS_EN: a zero divisor completes directly
//   from IDLE (quotient all-ones, remainder = dividend) without a request.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_i             div/mod instruction present in execute
//   op_signed_i         signed operation
//   op_rem_i            return remainder instead of quotient
//   dividend_i          dividend operand
//   divisor_i           divisor operand
//   flush_i             cancel the current operation
//   ack_i               execute stage consumes result_o
//   stall_o             pipeline stall request
//   done_o              result_o valid
//   result_o            selected quotient or remainder
//   timeout_o           sticky divider-timeout flag
//   cycle_cnt_o         cycles spent in WAIT for the current operation
//   div_valid_o         one-cycle request strobe to the divider
//   div_signed_o        signed/unsigned divider select
//   div_dividend_o      latched dividend
//   div_divisor_o       latched divisor
//   div_ready_i         divider result valid
//   div_result_i        divider result {quotient, remainder}

module div_ctrl
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH,
  parameter int TIMEOUT    = 64,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    op_signed_i,
  input  logic                    op_rem_i,
  input  logic [DATA_WIDTH-1:0]   dividend_i,
  input  logic [DATA_WIDTH-1:0]   divisor_i,
  input  logic                    flush_i,
  input  logic                    ack_i,
  output logic                    stall_o,
  output logic                    done_o,
  output logic [DATA_WIDTH-1:0]   result_o,
  output logic                    timeout_o,
  output logic [CNT_WIDTH-1:0]    cycle_cnt_o,
  output logic                    div_valid_o,
  output logic                    div_signed_o,
  output logic [DATA_WIDTH-1:0]   div_dividend_o,
  output logic [DATA_WIDTH-1:0]   div_divisor_o,
  input  logic                    div_ready_i,
  input  logic [2*DATA_WIDTH-1:0] div_result_i
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  div_state_e             state_q, state_d;
  logic                   op_signed_q, op_signed_d;
  logic                   op_rem_q, op_rem_d;
  logic [DATA_WIDTH-1:0]  dividend_q, dividend_d;
  logic [DATA_WIDTH-1:0]  divisor_q, divisor_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic                    accept;
  logic [2*DATA_WIDTH-1:0] sel_src;
  logic                    sel_rem;
  logic [DATA_WIDTH-1:0]   sel_result;

  // New operation accepted this cycle (also feeds the stall term).
  assign accept = (state_q == IDLE) && start_i && !flush_i;

`ifdef DIV_ZERO_BYPASS_EN
  logic bypass;

  // A zero divisor is answered locally; the select block then sees a
  // synthetic {all-ones, dividend} word and the live op_rem_i.
  always_comb begin
    bypass  = accept && (divisor_i == '0);
    sel_src = bypass ? {{DATA_WIDTH{1'b1}}, dividend_i} : div_result_i;
    sel_rem = bypass ? op_rem_i : op_rem_q;
  end
`else
  // Results only ever come from the divider.
  always_comb begin
    sel_src = div_result_i;
    sel_rem = op_rem_q;
  end
`endif

  div_result_sel #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_result_sel (
    .div_result_i(sel_src),
    .rem_sel_i   (sel_rem),
    .result_o    (sel_result)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_signed_q <= 1'b0;
      op_rem_q    <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      result_q    <= '0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_signed_q <= op_signed_d;
      op_rem_q    <= op_rem_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      result_q    <= result_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state and datapath updates. The cycle budget is shared between
  // WAIT and DRAIN, so a flushed operation cannot hang the controller.
  always_comb begin
    state_d     = state_q;
    op_signed_d = op_signed_q;
    op_rem_d    = op_rem_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    result_d    = result_q;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_signed_d = op_signed_i;
          op_rem_d    = op_rem_i;
          dividend_d  = dividend_i;
          divisor_d   = divisor_i;
          cnt_d       = '0;
          state_d     = ISSUE;
`ifdef DIV_ZERO_BYPASS_EN
          if (bypass) begin
            result_d = sel_result;
            state_d  = DONE;
          end
`endif
        end
      end
      ISSUE: begin
        state_d = flush_i ? DRAIN : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (flush_i) begin
          // A result arriving with the flush is already consumed, so
          // there is nothing left to drain.
          state_d = div_ready_i ? IDLE : DRAIN;
        end else if (div_ready_i) begin
          result_d = sel_result;
          state_d  = DONE;
        end else if (cnt_q >= CNT_LAST) begin
          timeout_d = 1'b1;
          result_d  = '0;
          state_d   = DONE;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + CNT_ONE;
        if (div_ready_i) begin
          state_d = IDLE;
        end else if (cnt_q >= CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      DONE: begin
        if (ack_i || flush_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    stall_o        = accept || (state_q == ISSUE) || (state_q == WAIT) || (state_q == DRAIN);
    done_o         = (state_q == DONE);
    div_valid_o    = (state_q == ISSUE);
    div_signed_o   = op_signed_q && (state_q != IDLE);
    result_o       = result_q;
    timeout_o      = timeout_q;
    cycle_cnt_o    = cnt_q;
    div_dividend_o = dividend_q;
    div_divisor_o  = divisor_q;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller between the execute stage and the shared 32-bit divider (signed and unsigned IP pair, AXI-stream-style valid/ready).
- Latches operands, issues a one-cycle request to the divider, and stalls the pipeline while the divider runs.
- Selects the quotient or remainder and holds it until the execute stage accepts it.
- Drains in-flight divider results after a pipeline flush so stale results never reach the pipeline.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- TIMEOUT, 64, maximum WAIT cycles before the operation is declared failed.
- CNT_WIDTH, 8, width of the cycle counter; must satisfy 2^CNT_WIDTH > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  execute stage holds a div/mod instruction
- op_signed_i  in  1  1 = div.w/mod.w, 0 = div.wu/mod.wu
- op_rem_i  in  1  1 = return remainder, 0 = return quotient
- dividend_i  in  DATA_WIDTH  dividend operand
- divisor_i  in  DATA_WIDTH  divisor operand
- flush_i  in  1  pipeline flush (exception/branch); cancels the current operation
- ack_i  in  1  execute stage advances and consumes result_o
- stall_o  out  1  pipeline stall request
- done_o  out  1  result_o valid
- result_o  out  DATA_WIDTH  selected quotient or remainder
- timeout_o  out  1  sticky divider-timeout error flag
- cycle_cnt_o  out  CNT_WIDTH  cycles spent in WAIT for the current operation
- div_valid_o  out  1  dividend and divisor valid to the divider (one shared strobe)
- div_signed_o  out  1  selects the signed or unsigned divider result
- div_dividend_o  out  DATA_WIDTH  latched dividend
- div_divisor_o  out  DATA_WIDTH  latched divisor
- div_ready_i  in  1  divider output valid
- div_result_i  in  2*DATA_WIDTH  divider output: [63:32] quotient, [31:0] remainder

Behaviour:
- Reset (synchronous, rst high at posedge):
  - state = IDLE.
  - All outputs 0, including timeout_o, cycle_cnt_o and the latched operands.
  - Reset mid-operation abandons the operation without draining; the divider is reset by the same rst.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE:
  - On start_i & !flush_i: latch operands, op_signed_i and op_rem_i, then go to ISSUE.
  - stall_o is asserted combinationally in this same cycle.
- ISSUE:
  - div_valid_o = 1 for exactly one cycle, then go to WAIT.
  - flush_i in ISSUE: the request is still issued, then go to DRAIN.
- WAIT:
  - cycle_cnt_o increments each cycle from 0.
  - div_ready_i: capture the quotient or remainder (per the latched op_rem) into result_o, then go to DONE.
  - cycle_cnt_o reaching TIMEOUT-1 without div_ready_i: set timeout_o, set result_o = 0, go to DONE.
  - flush_i without div_ready_i: go to DRAIN.
  - flush_i and div_ready_i in the same cycle: flush wins, result discarded, go to IDLE.
- DRAIN:
  - Wait for div_ready_i, discard it, go to IDLE.
  - The TIMEOUT limit also applies here: go to IDLE and set timeout_o.
  - start_i is ignored.
- DONE:
  - done_o = 1, stall_o = 0, result_o held stable.
  - ack_i or flush_i: go to IDLE; done_o drops the next cycle.
  - start_i is ignored in DONE; a new operation is accepted only from IDLE. This gives one idle bubble between back-to-back divides.
- stall_o = (IDLE & start_i & !flush_i) | ISSUE | WAIT | DRAIN.
- div_signed_o follows the latched op_signed from ISSUE through DONE.
- Latency from start to done_o = 2 + divider latency cycles.
- cycle_cnt_o clears on entry to ISSUE and holds its value in DONE.
- timeout_o clears only on rst.
- Signed overflow (0x80000000 / 0xFFFFFFFF) is passed through as the divider returns it; no special handling.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN
- With the macro:
  - IDLE with start_i and divisor_i == 0 goes directly to DONE; no divider request is made.
  - Quotient = all-ones; remainder = dividend_i.
  - stall_o is asserted for that one cycle only.
- Without the macro: a zero divisor is issued to the divider like any other operand; the result is whatever the divider returns.

Decomposition:
- Shared package div_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE, DRAIN);
  - the DIV_QUOT_MSB/LSB and DIV_REM_MSB/LSB slice constants;
  - the default DATA_WIDTH.
- Sub-module div_result_sel: combinational quotient/remainder slice and select, shared with the bypass path.

Test Plan:
- Signed divide: start div.w, 100 / -7, op_rem=0, divider returns after 34 cycles → stall_o high throughout; done_o with result_o = 0xFFFFFFF2 (-14); ack_i returns state to IDLE.
- Unsigned remainder: mod.wu 0xFFFFFFFF / 10 → result_o = 5; cycle_cnt_o equals the observed divider latency.
- Flush in WAIT: flush_i at cycle 10 → state DRAIN; the later div_ready_i is discarded; done_o never rises; a new start is accepted only after the drain completes.
- Hold in DONE: ack_i held low 5 cycles → done_o and result_o stable; start_i during DONE is ignored (div_valid_o stays 0).
- Timeout: div_ready_i never asserted → at cycle TIMEOUT (64) timeout_o = 1, done_o with result_o = 0; timeout_o stays set until rst.
- Zero divisor: 123 / 0, op_rem=1 → with DIV_ZERO_BYPASS_EN, done_o the next cycle with result 123 and no div_valid_o; without the macro, the request is issued to the divider.
